// File: rtl/snitch_vfpr_reader.sv
// snitch_vfpr_reader: in-order TCDM read streamer for the vector FP regfile.
// Define SNITCH_VFPR_READER_TRACE_EN to print request/response traces.
package snitch_vfpr_reader_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  amo;
      logic [63:0] data;
      logic [7:0]  strb;
      logic        user;
   } tcdm_req_chan_t;

   typedef struct packed {
      logic           q_valid;
      tcdm_req_chan_t q;
   } tcdm_req_t;

   typedef struct packed {
      logic [63:0] data;
   } tcdm_rsp_chan_t;

   typedef struct packed {
      logic           q_ready;
      logic           p_valid;
      tcdm_rsp_chan_t p;
   } tcdm_rsp_t;

endpackage

module snitch_vfpr_reader #(
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned LenWidth       = 8,
   parameter int unsigned NumOutstanding = 4,
   parameter type tcdm_req_t = snitch_vfpr_reader_pkg::tcdm_req_t,
   parameter type tcdm_rsp_t = snitch_vfpr_reader_pkg::tcdm_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [AddrWidth-1:0] cmd_addr_i,
   input  logic [LenWidth-1:0]  cmd_len_i,
   output tcdm_req_t            rd_req_o,
   input  tcdm_rsp_t            rd_rsp_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 data_valid_o,
   input  logic                 data_ready_i,
   output logic                 data_last_o,
   output logic                 busy_o
);

   localparam int unsigned BeatBytes = DataWidth / 8;
   localparam int unsigned CntW = $clog2(NumOutstanding + 1);
   localparam int unsigned PtrW =
      (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

   localparam logic [AddrWidth-1:0] AddrStep =
      AddrWidth'(BeatBytes);
   localparam logic [AddrWidth-1:0] AddrMask =
      ~AddrWidth'(BeatBytes - 1);
   localparam logic [CntW:0] Credits =
      (CntW + 1)'(NumOutstanding);
   localparam logic [PtrW-1:0] PtrLast =
      PtrW'(NumOutstanding - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_e;

   state_e               state_q;
   logic [AddrWidth-1:0] addr_q;
   logic [LenWidth-1:0]  remaining_q;
   logic [LenWidth-1:0]  len_q;
   logic [LenWidth-1:0]  beat_q;
   logic [CntW-1:0]      outstanding_q;
   logic [CntW-1:0]      fifo_cnt_q;
   logic [PtrW-1:0]      wptr_q;
   logic [PtrW-1:0]      rptr_q;
   logic [DataWidth-1:0] mem_q [NumOutstanding];

   logic [CntW:0] in_use;
   logic          q_valid;
   logic          req_hs;
   logic          rsp_push;
   logic          pop;
   logic          last_hs;

   function automatic logic [PtrW-1:0] ptr_inc(
      input logic [PtrW-1:0] p
   );
      return (p == PtrLast) ? '0 : p + PtrW'(1);
   endfunction

   // Buffered beats count against the credit too, so the FIFO can't overflow.
   assign in_use   = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
   assign q_valid  = (state_q == ISSUE) && (in_use < Credits);
   assign req_hs   = q_valid && rd_rsp_i.q_ready;
   assign rsp_push = rd_rsp_i.p_valid && (outstanding_q != '0);

   assign data_valid_o = (fifo_cnt_q != '0);
   assign data_o       = data_valid_o ? mem_q[rptr_q] : '0;
   assign data_last_o  = data_valid_o && (beat_q == len_q);
   assign pop          = data_valid_o && data_ready_i;
   assign last_hs      = pop && data_last_o;

   assign cmd_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);

   always_comb begin
      rd_req_o         = '0;
      rd_req_o.q_valid = q_valid;
      rd_req_o.q.addr  = addr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         len_q         <= '0;
         beat_q        <= '0;
         outstanding_q <= '0;
         fifo_cnt_q    <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
      end else begin
         if (pop) begin
            beat_q <= beat_q + LenWidth'(1);
            rptr_q <= ptr_inc(rptr_q);
         end
         if (rsp_push) begin
            wptr_q <= ptr_inc(wptr_q);
         end

         unique case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  addr_q      <= cmd_addr_i & AddrMask;
                  remaining_q <= cmd_len_i;
                  len_q       <= cmd_len_i;
                  beat_q      <= '0;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (req_hs) begin
                  addr_q      <= addr_q + AddrStep;
                  remaining_q <= remaining_q - LenWidth'(1);
                  if (remaining_q == '0) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (last_hs) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         unique case ({req_hs, rsp_push})
            2'b10:   outstanding_q <= outstanding_q + CntW'(1);
            2'b01:   outstanding_q <= outstanding_q - CntW'(1);
            default: outstanding_q <= outstanding_q;
         endcase

         unique case ({rsp_push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (rsp_push) begin
         mem_q[wptr_q] <= rd_rsp_i.p.data;
      end
   end

`ifdef SNITCH_VFPR_READER_TRACE_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i && req_hs) begin
         $display("- rd: [%h]", addr_q);
      end
      if (!rst_i && rsp_push) begin
         $display("- rd rsp: %h", rd_rsp_i.p.data);
      end
   end
`else
`endif

endmodule

// File: tb/tb_snitch_vfpr_reader.sv
// tb_snitch_vfpr_reader: directed scoreboard bench for snitch_vfpr_reader.
// Uses NumOutstanding=2 and a 1-cycle-latency TCDM responder.
`timescale 1ns/1ps
module tb_snitch_vfpr_reader;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 32;
   localparam int unsigned LW = 8;
   localparam int unsigned NO = 2;

   typedef snitch_vfpr_reader_pkg::tcdm_req_t req_t;
   typedef snitch_vfpr_reader_pkg::tcdm_rsp_t rsp_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   req_t          rd_req;
   rsp_t          rd_rsp;
   logic [DW-1:0] data;
   logic          data_valid;
   logic          data_ready;
   logic          data_last;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int req_cnt = 0;
   int beat_cnt = 0;
   bit qr_rand = 0;
   bit inject = 0;
   bit chk_idle_next = 0;

   logic [AW-1:0] exp_addr_q [$];
   beat_t         exp_beat_q [$];

   always #5 clk = ~clk;

   snitch_vfpr_reader #(
      .DataWidth      (DW),
      .AddrWidth      (AW),
      .LenWidth       (LW),
      .NumOutstanding (NO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_addr_i   (cmd_addr),
      .cmd_len_i    (cmd_len),
      .rd_req_o     (rd_req),
      .rd_rsp_i     (rd_rsp),
      .data_o       (data),
      .data_valid_o (data_valid),
      .data_ready_i (data_ready),
      .data_last_o  (data_last),
      .busy_o       (busy)
   );

   function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
      return {a ^ 32'hC0DE_5A5A, a};
   endfunction

   task automatic chk(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [AW-1:0] a,
                           input logic [LW-1:0] l);
      logic [AW-1:0] cur;
      beat_t b;
      cur = a & ~AW'(DW / 8 - 1);
      for (int i = 0; i <= int'(l); i++) begin
         exp_addr_q.push_back(cur);
         b.data = mkdata(cur);
         b.last = (i == int'(l));
         exp_beat_q.push_back(b);
         cur = cur + AW'(DW / 8);
      end
   endtask

   task automatic send_cmd(input logic [AW-1:0] a,
                           input logic [LW-1:0] l);
      bit done;
      push_exp(a, l);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         done = cmd_ready;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!done) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         ok = !busy && (exp_beat_q.size() == 0);
      end
      chk(tag, ok, 1);
      @(posedge clk);
      #1;
   endtask

   // TCDM model: one-cycle read latency, never stalls p_valid.
   initial begin
      logic          hs;
      logic          inj;
      logic [AW-1:0] a;
      rd_rsp         = '0;
      rd_rsp.q_ready = 1'b1;
      forever begin
         @(negedge clk);
         hs  = rd_req.q_valid && rd_rsp.q_ready;
         inj = inject;
         a   = rd_req.q.addr;
         @(posedge clk);
         #1;
         rd_rsp.p_valid = hs | inj;
         rd_rsp.p.data  = hs ? mkdata(a) : 64'hDEAD_BEEF_0BAD_F00D;
         rd_rsp.q_ready = qr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: scoreboard pops plus handshake stability.
   initial begin
      bit            pv, pr, dv, dr, rst_prev;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      logic          pl;
      beat_t         b;
      pv = 0; pr = 0; dv = 0; dr = 0; rst_prev = 1;
      pa = '0; pd = '0; pl = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_idle_next) begin
            chk("busy_after_last", busy, 0);
            chk_idle_next = 0;
         end
         if (!rst_prev) begin
            if (pv && !pr) begin
               chk("qv_hold", rd_req.q_valid, 1);
               chk("addr_hold", rd_req.q.addr, pa);
            end
            if (dv && !dr) begin
               chk("dv_hold", data_valid, 1);
               chk("data_hold", data, pd);
               chk("last_hold", data_last, pl);
            end
         end
         if (!rst && rd_req.q_valid && rd_rsp.q_ready) begin
            req_cnt++;
            if (exp_addr_q.size() == 0)
               chk("req_unexpected", 0, 1);
            else
               chk("req_addr", rd_req.q.addr, exp_addr_q.pop_front());
         end
         if (!rst && data_valid && data_ready) begin
            beat_cnt++;
            if (exp_beat_q.size() == 0) begin
               chk("beat_unexpected", 0, 1);
            end else begin
               b = exp_beat_q.pop_front();
               chk("beat_data", data, b.data);
               chk("beat_last", data_last, b.last);
            end
            if (data_last) chk_idle_next = 1;
         end
         rst_prev = rst;
         pv = rd_req.q_valid;
         pr = rd_rsp.q_ready;
         pa = rd_req.q.addr;
         dv = data_valid;
         dr = data_ready;
         pd = data;
         pl = data_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  base;
      bit  done;
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_len    = '0;
      data_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_req_zero", rd_req === '0, 1);
      chk("rst_dv", data_valid, 0);
      chk("rst_last", data_last, 0);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      data_ready = 1'b1;

      // basic 4-beat read and first-beat latency
      send_cmd(32'h100, 8'd3);
      @(negedge clk);
      chk("t1_qv_c1", rd_req.q_valid, 1);
      chk("t1_dv_c1", data_valid, 0);
      @(negedge clk);
      chk("t1_dv_c2", data_valid, 0);
      @(negedge clk);
      chk("t1_dv_c3", data_valid, 1);
      wait_idle("t1_idle");

      // unaligned base address
      send_cmd(32'h107, 8'd0);
      wait_idle("t2_idle");

      // credit limit under output backpressure
      data_ready = 1'b0;
      base = req_cnt;
      send_cmd(32'h400, 8'd7);
      repeat (10) @(negedge clk);
      chk("t3_req_cnt", req_cnt - base, NO);
      chk("t3_qv_low", rd_req.q_valid, 0);
      chk("t3_dv_held", data_valid, 1);
      @(posedge clk);
      #1;
      data_ready = 1'b1;
      base = beat_cnt;
      wait_idle("t3_idle");
      chk("t3_beats", beat_cnt - base, 8);

      // address wrap
      send_cmd(32'hFFFF_FFF8, 8'd1);
      wait_idle("t4_idle");

      // reset while requests are in flight
      data_ready = 1'b0;
      send_cmd(32'h200, 8'd7);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_addr_q.delete();
      exp_beat_q.delete();
      inject = 1;
      @(negedge clk);
      chk("t5_cmd_ready", cmd_ready, 1);
      chk("t5_dv", data_valid, 0);
      chk("t5_busy", busy, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      inject = 0;
      repeat (4) @(negedge clk);
      chk("t5_dv_after", data_valid, 0);
      chk("t5_data_after", data, 0);
      chk("t5_req_zero", rd_req === '0, 1);
      @(posedge clk);
      #1;
      data_ready = 1'b1;
      base = beat_cnt;
      send_cmd(32'h300, 8'd0);
      wait_idle("t5_idle");
      chk("t5_one_beat", beat_cnt - base, 1);

      // command held under random q_ready stalls
      qr_rand = 1;
      send_cmd(32'h500, 8'd5);
      push_exp(32'h600, 8'd2);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h600;
      cmd_len   = 8'd2;
      done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (data_valid && data_ready && data_last) done = 1;
         chk("t6_cmd_ready_low", cmd_ready, 0);
      end
      chk("t6_last_seen", done, 1);
      @(negedge clk);
      chk("t6_cmd_ready_high", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_idle("t6_idle");
      qr_rand = 0;

      chk("end_addr_q", exp_addr_q.size(), 0);
      chk("end_beat_q", exp_beat_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
